rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Sequences all writes into the 32x32 register file's single write port (wAddr/wDin/wEna) and tracks which registers have writes pending.
- Two writeback requesters compete for the port: the ALU result path and the memory-load path. Arbitration is round-robin with a valid/ready handshake.
- A per-register busy scoreboard is set at instruction issue and cleared at writeback. It drives a hazard signal that the multicycle control FSM uses to hold the decode/read state.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NREGS, 32, number of registers tracked (must equal 2**ADDR_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- issue_valid  in  1  instruction with a destination register is issuing
- issue_rd  in  ADDR_W  destination register of the issuing instruction
- issue_ready  out  1  issue accepted this cycle
- chk_rs1  in  ADDR_W  source register 1 being read
- chk_rs2  in  ADDR_W  source register 2 being read
- hazard  out  1  a source register has a pending write
- flush  in  1  discard all pending-write tracking
- alu_valid  in  1  ALU writeback request
- alu_addr  in  ADDR_W  ALU writeback register
- alu_data  in  DATA_W  ALU writeback data
- alu_ready  out  1  ALU request granted
- mem_valid  in  1  load writeback request
- mem_addr  in  ADDR_W  load writeback register
- mem_data  in  DATA_W  load writeback data
- mem_ready  out  1  load request granted
- rf_wEna  out  1  to register file wEna
- rf_wAddr  out  ADDR_W  to register file wAddr
- rf_wDin  out  DATA_W  to register file wDin
- busy_vec  out  NREGS  scoreboard state, bit i = register i pending
- err_stray  out  1  sticky: a writeback targeted a non-busy register

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. The following apply at the rising edge with rst_n=0:
  - busy_vec=0, rf_wEna=0, rf_wAddr=0, rf_wDin=0, err_stray=0.
  - The last-grant pointer is set to MEM, so the ALU wins the first tie.
  - alu_ready, mem_ready and issue_ready are forced 0 while rst_n=0.
  - A reset asserted mid-operation drops any in-flight request; nothing is written that cycle.
- Arbitration is combinational within the cycle:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: grant goes to the requester not granted last.
  - A transfer occurs at the clock edge when valid & ready. The last-grant pointer updates only on a transfer.
  - Requesters hold addr/data stable while valid and not ready. Once asserted, valid stays high until the transfer.
- Write port latency is 1 cycle:
  - A transfer at edge N drives rf_wEna=1 with the registered addr/data during cycle N+1.
  - With no transfer, rf_wEna=0 in that cycle; rf_wAddr/rf_wDin hold their previous values.
  - Back-to-back transfers produce one write per cycle with no bubble.
- Scoreboard clear: a transfer to register r clears busy[r] at the same edge the write is registered.
- Stray writes: a transfer to a register with busy[r]=0 still performs the write and sets err_stray=1. err_stray is cleared only by reset.
- Scoreboard set:
  - issue_ready = ~busy[issue_rd] & rst_n. A WAW to a busy register stalls issue.
  - On issue_valid & issue_ready, busy[issue_rd] is set at the edge.
  - Simultaneous set of register a and clear of register b (a != b): both take effect.
  - Set and clear of the same register in the same cycle cannot occur legally, because issue_ready=0 while the register is busy. If the register is not busy, the clear is a stray (err_stray) and the set wins: the bit ends at 1.
- Hazard:
  - hazard = busy[chk_rs1] | busy[chk_rs2], purely combinational from the registered busy_vec. There is no bypass.
  - A register cleared at edge N reads non-hazardous from cycle N+1, the same cycle its data is being written.
  - The register file read is combinational and its write lands at the end of N+1. The control FSM must therefore sample read data no earlier than cycle N+2 after the clear.
- Flush:
  - flush=1 clears every busy bit at the edge. Flush has priority over an issue set in the same cycle: the set is dropped, although issue_ready still reads 1.
  - Flush does not cancel an arbitration transfer or a pending rf_wEna. Writebacks arriving after a flush flag err_stray.
- All register-address arithmetic is modulo NREGS. No register index is special; register 0 is tracked and written like any other.

Test Plan:
1. Reset, then issue rd=5 -> busy_vec=0x00000020. Then alu_valid with addr=5, data=0xDEADBEEF -> alu_ready=1; in the next cycle rf_wEna=1, rf_wAddr=5, rf_wDin=0xDEADBEEF, and busy_vec=0.
2. Issue rd=3 and rd=7, then hold alu_valid (addr=3) and mem_valid (addr=7) together for 2 cycles:
   - First cycle: ALU granted. Second cycle: MEM granted.
   - Write sequence is reg 3 then reg 7 on consecutive cycles; err_stray stays 0.
3. With busy[9]=1, set chk_rs1=9 -> hazard=1. Issue rd=9 -> issue_ready=0. Write back reg 9 -> hazard=0 in the next cycle and issue_ready returns to 1.
4. mem_valid with addr=12 while busy[12]=0 -> the write occurs and err_stray=1. err_stray stays 1 through further traffic until rst_n=0.
5. Issue rd=4 and flush in the same cycle while busy[2]=1 -> busy_vec=0 afterwards. Then a pending ALU writeback to reg 2 -> written, err_stray=1.
6. Drive rst_n=0 while alu_valid=1 and busy_vec=0x0000FFFF -> alu_ready=0, and the following cycle shows rf_wEna=0 and busy_vec=0. After release, the ALU wins the first tie.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for the 32x32 register file: round-robin arbitration between
// the ALU and load writeback paths, plus a per-register pending-write scoreboard.
module rf_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              hazard,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_wEna,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wDin,
  output logic [NREGS-1:0]  busy_vec,
  output logic              err_stray
);

  // Handshake: a requester raises valid with stable addr/data and keeps it up until
  // the cycle ready is also high; that edge is the transfer. ready is only ever
  // given to a requester that is valid, and never while rst_n is low.

  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  set_mask;
  logic [NREGS-1:0]  clr_mask;
  logic [NREGS-1:0]  busy_next;
  logic              last_mem_q;
  logic              alu_xfer;
  logic              mem_xfer;
  logic              any_xfer;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // On a tie the requester that did not win the previous transfer is granted.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (rst_n) begin
      if (alu_valid && mem_valid) begin
        alu_ready = last_mem_q;
        mem_ready = ~last_mem_q;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign alu_xfer = alu_valid & alu_ready;
  assign mem_xfer = mem_valid & mem_ready;
  assign any_xfer = alu_xfer | mem_xfer;
  assign wb_addr  = alu_xfer ? alu_addr : mem_addr;
  assign wb_data  = alu_xfer ? alu_data : mem_data;

  assign issue_ready = rst_n & ~busy_q[issue_rd];
  assign hazard      = busy_q[chk_rs1] | busy_q[chk_rs2];
  assign busy_vec    = busy_q;

  // Set beats clear on the same register; flush beats everything.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_ready) set_mask[issue_rd] = 1'b1;
    if (any_xfer) clr_mask[wb_addr] = 1'b1;
    busy_next = flush ? '0 : ((busy_q & ~clr_mask) | set_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      last_mem_q <= 1'b1;
      rf_wEna    <= 1'b0;
      rf_wAddr   <= '0;
      rf_wDin    <= '0;
      err_stray  <= 1'b0;
    end else begin
      busy_q  <= busy_next;
      rf_wEna <= any_xfer;
      if (any_xfer) begin
        rf_wAddr   <= wb_addr;
        rf_wDin    <= wb_data;
        last_mem_q <= mem_xfer;
        if (!busy_q[wb_addr]) err_stray <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios plus randomized traffic checked
// against an array/queue model of the scoreboard, arbiter and write port.
module tb_rf_wb_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rd = '0;
  logic          issue_ready;
  logic [AW-1:0] chk_rs1 = '0;
  logic [AW-1:0] chk_rs2 = '0;
  logic          hazard;
  logic          flush = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic          rf_wEna;
  logic [AW-1:0] rf_wAddr;
  logic [DW-1:0] rf_wDin;
  logic [NR-1:0] busy_vec;
  logic          err_stray;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard), .flush(flush),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_wEna(rf_wEna), .rf_wAddr(rf_wAddr), .rf_wDin(rf_wDin),
    .busy_vec(busy_vec), .err_stray(err_stray)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: pending flags per register, who won last, sticky error, write queue.
  bit            m_busy[NR];
  bit            m_last_mem;
  bit            m_err;
  bit            m_wena;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdin;
  logic [AW+DW-1:0] exp_q[$];
  logic p_alu, p_mem, p_issue, p_haz;
  logic o_alu, o_mem, o_issue, o_haz;

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic void predict();
    p_issue = rst_n && !m_busy[issue_rd];
    p_haz   = m_busy[chk_rs1] || m_busy[chk_rs2];
    if (!rst_n) begin
      p_alu = 1'b0;
      p_mem = 1'b0;
    end else if (alu_valid && mem_valid) begin
      p_alu = m_last_mem;
      p_mem = !m_last_mem;
    end else begin
      p_alu = alu_valid;
      p_mem = mem_valid;
    end
  endfunction

  function automatic void commit();
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW+DW-1:0] ent;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_last_mem = 1'b1;
      m_err = 1'b0;
      m_wena = 1'b0;
      m_waddr = '0;
      m_wdin = '0;
      exp_q.delete();
      return;
    end
    m_wena = p_alu || p_mem;
    if (m_wena) begin
      wa = p_alu ? alu_addr : mem_addr;
      wd = p_alu ? alu_data : mem_data;
      if (!m_busy[wa]) m_err = 1'b1;
      m_busy[wa] = 1'b0;
      m_last_mem = p_mem;
      exp_q.push_back({wa, wd});
    end
    if (issue_valid && p_issue) m_busy[issue_rd] = 1'b1;
    if (flush) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    if (m_wena && exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      m_waddr = ent[AW+DW-1:DW];
      m_wdin  = ent[DW-1:0];
    end
  endfunction

  // One clock: sample combinational outputs before the edge, advance the model at it.
  task automatic step();
    #1;
    predict();
    o_alu = alu_ready;
    o_mem = mem_ready;
    o_issue = issue_ready;
    o_haz = hazard;
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk_rs1 = '0; chk_rs2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd3; mem_valid = 1'b1; mem_addr = 5'd4;
    step();
    n_total++; if ({o_alu, o_mem, o_issue} !== 3'b000) $display("FAIL reset_ready: got %b expected 000", {o_alu, o_mem, o_issue}); else n_pass++;
    n_total++; if (busy_vec !== 32'h0) $display("FAIL reset_busy: got %h expected 0", busy_vec); else n_pass++;
    n_total++; if ({rf_wEna, rf_wAddr, rf_wDin, err_stray} !== '0) $display("FAIL reset_wport: got %b/%h/%h/%b expected zeros", rf_wEna, rf_wAddr, rf_wDin, err_stray); else n_pass++;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_write();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    n_total++; if (o_issue !== 1'b1) $display("FAIL basic_issue_ready: got %b expected 1", o_issue); else n_pass++;
    n_total++; if (busy_vec !== 32'h0000_0020 || busy_vec !== m_vec()) $display("FAIL basic_busy_set: got %h expected %h", busy_vec, 32'h20); else n_pass++;
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 1'b0;
    n_total++; if (o_alu !== 1'b1) $display("FAIL basic_alu_ready: got %b expected 1", o_alu); else n_pass++;
    n_total++; if ({rf_wEna, rf_wAddr, rf_wDin} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) $display("FAIL basic_write: got %b/%0d/%h expected 1/5/deadbeef", rf_wEna, rf_wAddr, rf_wDin); else n_pass++;
    n_total++; if (busy_vec !== 32'h0) $display("FAIL basic_busy_clr: got %h expected 0", busy_vec); else n_pass++;
    step();
    n_total++; if ({rf_wEna, rf_wAddr, rf_wDin} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) $display("FAIL basic_hold: got %b/%0d/%h expected 0/5/deadbeef", rf_wEna, rf_wAddr, rf_wDin); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_a[3];
    logic [AW-1:0] got_a[3];
    do_reset();
    issue_valid = 1'b1;
    issue_rd = 5'd3; step();
    issue_rd = 5'd7; step();
    issue_rd = 5'd4; step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1111_0003;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h2222_0007;
    step();
    got_a[0] = rf_wAddr;
    n_total++; if ({o_alu, o_mem} !== 2'b10) $display("FAIL b2b_tie1: got %b expected 10", {o_alu, o_mem}); else n_pass++;
    alu_addr = 5'd4; alu_data = 32'h1111_0004;
    step();
    got_a[1] = rf_wAddr;
    n_total++; if ({o_alu, o_mem} !== 2'b01) $display("FAIL b2b_tie2: got %b expected 01", {o_alu, o_mem}); else n_pass++;
    n_total++; if ({rf_wEna, rf_wDin} !== {1'b1, 32'h2222_0007}) $display("FAIL b2b_mem_data: got %b/%h expected 1/22220007", rf_wEna, rf_wDin); else n_pass++;
    mem_valid = 1'b0;
    step();
    got_a[2] = rf_wAddr;
    alu_valid = 1'b0;
    exp_a[0] = 5'd3; exp_a[1] = 5'd7; exp_a[2] = 5'd4;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (got_a[i] !== exp_a[i]) $display("FAIL b2b_order%0d: got %0d expected %0d", i, got_a[i], exp_a[i]); else n_pass++;
    end
    n_total++; if ({rf_wEna, err_stray, busy_vec} !== {1'b1, 1'b0, 32'h0}) $display("FAIL b2b_end: got %b/%b/%h expected 1/0/0", rf_wEna, err_stray, busy_vec); else n_pass++;
  endtask

  task automatic test_hazard();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    chk_rs1 = 5'd9;
    step();
    n_total++; if ({o_haz, o_issue} !== 2'b10) $display("FAIL haz_waw: got haz/issue %b expected 10", {o_haz, o_issue}); else n_pass++;
    n_total++; if (busy_vec !== 32'h0000_0200) $display("FAIL haz_busy: got %h expected 00000200", busy_vec); else n_pass++;
    issue_valid = 1'b0; chk_rs1 = 5'd0; chk_rs2 = 5'd9;
    step();
    n_total++; if (o_haz !== 1'b1) $display("FAIL haz_rs2: got %b expected 1", o_haz); else n_pass++;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h0000_0909; issue_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    n_total++; if ({hazard, issue_ready, rf_wEna} !== 3'b011) $display("FAIL haz_clear: got haz/issue/wena %b expected 011", {hazard, issue_ready, rf_wEna}); else n_pass++;
    issue_valid = 1'b0;
  endtask

  task automatic test_stray();
    do_reset();
    mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'hC0DE_000C;
    step();
    mem_valid = 1'b0;
    n_total++; if ({rf_wEna, rf_wAddr, err_stray} !== {1'b1, 5'd12, 1'b1}) $display("FAIL stray_flag: got %b/%0d/%b expected 1/12/1", rf_wEna, rf_wAddr, err_stray); else n_pass++;
    issue_valid = 1'b1; issue_rd = 5'd1; step();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h5; step();
    alu_valid = 1'b0; step();
    n_total++; if (err_stray !== 1'b1) $display("FAIL stray_sticky: got %b expected 1", err_stray); else n_pass++;
    do_reset();
    n_total++; if (err_stray !== 1'b0) $display("FAIL stray_reset: got %b expected 0", err_stray); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd2; step();
    issue_rd = 5'd4; flush = 1'b1; step();
    n_total++; if (o_issue !== 1'b1) $display("FAIL flush_issue_ready: got %b expected 1", o_issue); else n_pass++;
    n_total++; if (busy_vec !== 32'h0) $display("FAIL flush_busy: got %h expected 0", busy_vec); else n_pass++;
    issue_valid = 1'b0; flush = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'hF1F1_0002;
    step();
    alu_valid = 1'b0;
    n_total++; if ({o_alu, rf_wEna, rf_wAddr, rf_wDin, err_stray} !== {2'b11, 5'd2, 32'hF1F1_0002, 1'b1}) $display("FAIL flush_late_wb: got %b%b/%0d/%h/%b expected 11/2/f1f10002/1", o_alu, rf_wEna, rf_wAddr, rf_wDin, err_stray); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue_rd = AW'(i);
      step();
    end
    issue_valid = 1'b0;
    n_total++; if (busy_vec !== 32'h0000_FFFF) $display("FAIL rmid_fill: got %h expected 0000ffff", busy_vec); else n_pass++;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hAAAA_0000;
    mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'hBBBB_0001;
    rst_n = 1'b0;
    step();
    n_total++; if ({o_alu, o_mem, o_issue} !== 3'b000) $display("FAIL rmid_ready: got %b expected 000", {o_alu, o_mem, o_issue}); else n_pass++;
    n_total++; if ({rf_wEna, busy_vec} !== {1'b0, 32'h0}) $display("FAIL rmid_drop: got %b/%h expected 0/0", rf_wEna, busy_vec); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if ({o_alu, o_mem} !== 2'b10) $display("FAIL rmid_first_tie: got %b expected 10", {o_alu, o_mem}); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if (!rst_n) begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
      end else begin
        if (!alu_valid) begin
          alu_valid = ($urandom_range(0, 2) == 0);
          alu_addr = AW'($urandom_range(0, 7));
          alu_data = $urandom;
        end
        if (!mem_valid) begin
          mem_valid = ($urandom_range(0, 2) == 0);
          mem_addr = AW'($urandom_range(0, 7));
          mem_data = $urandom;
        end
      end
      issue_valid = $urandom_range(0, 1);
      issue_rd = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      chk_rs1 = AW'($urandom_range(0, 9));
      chk_rs2 = AW'($urandom_range(0, 9));
      flush = ($urandom_range(0, 39) == 0);
      step();
      n_total++; if ({o_alu, o_mem, o_issue, o_haz} !== {p_alu, p_mem, p_issue, p_haz}) $display("FAIL rnd_comb c%0d: got %b expected %b", c, {o_alu, o_mem, o_issue, o_haz}, {p_alu, p_mem, p_issue, p_haz}); else n_pass++;
      n_total++; if ({rf_wEna, rf_wAddr, rf_wDin} !== {m_wena, m_waddr, m_wdin}) $display("FAIL rnd_wport c%0d: got %b/%0d/%h expected %b/%0d/%h", c, rf_wEna, rf_wAddr, rf_wDin, m_wena, m_waddr, m_wdin); else n_pass++;
      n_total++; if ({busy_vec, err_stray} !== {m_vec(), m_err}) $display("FAIL rnd_state c%0d: got %h/%b expected %h/%b", c, busy_vec, err_stray, m_vec(), m_err); else n_pass++;
      if (o_alu) alu_valid = 1'b0;
      if (o_mem) mem_valid = 1'b0;
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_hazard();
    test_stray();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
